// File: rtl/adc_capture_gate.sv
// Gates a free-running ADC stream open for LENGTH cycles, DELAY cycles after a capture edge.
// Define ADC_CAPTURE_GATE_RETRIGGER_EN to let a capture edge during OPEN restart the window.
module adc_capture_gate #(
  parameter int unsigned DELAY  = 96,
  parameter int unsigned LENGTH = 32,
  parameter int unsigned WIDTH  = 128
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             capture_i,
  input  logic [WIDTH-1:0] adc_tdata,
  input  logic             adc_tvalid,
  output logic             adc_tready,
  output logic [WIDTH-1:0] gate_tdata,
  output logic             gate_tvalid,
  input  logic             gate_tready,
  output logic             busy_o,
  output logic [15:0]      window_count_o
);

  if (LENGTH == 0 || LENGTH > 65535 || DELAY > 65535) begin : g_param_check
    $error("adc_capture_gate: LENGTH must be 1..65535 and DELAY 0..65535");
  end

  localparam logic [15:0] DELAY_LAST  = 16'(DELAY == 0 ? 0 : DELAY - 1);
  localparam logic [15:0] LENGTH_LAST = 16'(LENGTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELAY = 2'd1,
    S_OPEN  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic        meta;
  logic [1:0]  sync;
  logic [1:0]  fill;
  logic        cap_edge;
  logic        unused_inputs;

  assign cap_edge      = sync[0] & ~sync[1];
  assign busy_o        = (state != S_IDLE);
  assign adc_tready    = 1'b1;
  assign unused_inputs = adc_tvalid ^ gate_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state          <= S_IDLE;
      cnt            <= '0;
      meta           <= 1'b0;
      sync           <= 2'b10;
      fill           <= 2'b00;
      gate_tdata     <= '0;
      gate_tvalid    <= 1'b0;
      window_count_o <= '0;
    end else begin
      meta    <= capture_i;
      sync[0] <= meta;
      // sync[1] stays high until a genuine post-reset sample reaches sync[0],
      // so a capture line held high across reset cannot look like an edge.
      sync[1] <= fill[1] ? sync[0] : 1'b1;
      fill    <= {fill[0], 1'b1};

      gate_tvalid <= 1'b1;
      gate_tdata  <= (state == S_OPEN) ? adc_tdata : '0;

      case (state)
        S_IDLE: begin
          if (cap_edge) begin
            cnt   <= '0;
            state <= (DELAY == 0) ? S_OPEN : S_DELAY;
          end
        end
        S_DELAY: begin
          if (cnt == DELAY_LAST) begin
            cnt   <= '0;
            state <= S_OPEN;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_OPEN: begin
          // Closure wins over a coincident edge: no back-to-back windows.
          if (cnt == LENGTH_LAST) begin
            cnt            <= '0;
            state          <= S_IDLE;
            window_count_o <= window_count_o + 16'd1;
          end
`ifdef ADC_CAPTURE_GATE_RETRIGGER_EN
          else if (cap_edge) begin
            cnt <= '0;
          end
`endif
          else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_gate.sv
// Directed bench for adc_capture_gate: two instances (DELAY=4/LENGTH=8 and DELAY=0/LENGTH=1)
// with a queue of expected gated beats checked as the DUTs emit them.
module tb_adc_capture_gate;

  logic         clk = 1'b0;
  logic         rstn_a, rstn_b, cap_a, cap_b;
  logic [127:0] adc;
  logic         tvalid_in;
  logic         ready_a, ready_b, tvalid_a, tvalid_b, busy_a, busy_b;
  logic [127:0] gate_a, gate_b;
  logic [15:0]  count_a, count_b;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int beats_a, beats_b, busy_a_cnt, busy_b_cnt;
  int t, t2, exp_beats;
  logic [127:0] qa[$];
  logic [127:0] qb[$];

  always #5 clk = ~clk;

  adc_capture_gate #(.DELAY(4), .LENGTH(8), .WIDTH(128)) u_a (
    .aclk(clk), .aresetn(rstn_a), .capture_i(cap_a),
    .adc_tdata(adc), .adc_tvalid(tvalid_in), .adc_tready(ready_a),
    .gate_tdata(gate_a), .gate_tvalid(tvalid_a), .gate_tready(1'b1),
    .busy_o(busy_a), .window_count_o(count_a)
  );

  adc_capture_gate #(.DELAY(0), .LENGTH(1), .WIDTH(128)) u_b (
    .aclk(clk), .aresetn(rstn_b), .capture_i(cap_b),
    .adc_tdata(adc), .adc_tvalid(tvalid_in), .adc_tready(ready_b),
    .gate_tdata(gate_b), .gate_tvalid(tvalid_b), .gate_tready(1'b0),
    .busy_o(busy_b), .window_count_o(count_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs 1 time unit after the edge, then present the next ADC word.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (gate_a !== '0) begin
      beats_a++;
      if (qa.size() == 0) chk("a_unexpected_beat", gate_a, '0);
      else chk("a_beat", gate_a, qa.pop_front());
    end
    if (gate_b !== '0) begin
      beats_b++;
      if (qb.size() == 0) chk("b_unexpected_beat", gate_b, '0);
      else chk("b_beat", gate_b, qb.pop_front());
    end
    if (busy_a === 1'b1) busy_a_cnt++;
    if (busy_b === 1'b1) busy_b_cnt++;
    adc = 128'(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_a(output int ts);
    cap_a = 1'b1;
    tick();
    cap_a = 1'b0;
    ts = cyc;
  endtask

  task automatic pulse_b(output int ts);
    cap_b = 1'b1;
    tick();
    cap_b = 1'b0;
    ts = cyc;
  endtask

  task automatic push_a(input int first, input int n);
    for (int i = 0; i < n; i++) qa.push_back(128'(first + i));
  endtask

  task automatic push_b(input int first, input int n);
    for (int i = 0; i < n; i++) qb.push_back(128'(first + i));
  endtask

  initial begin
    rstn_a = 1'b0; rstn_b = 1'b0; cap_a = 1'b0; cap_b = 1'b0;
    adc = '0; tvalid_in = 1'b0;
    beats_a = 0; beats_b = 0; busy_a_cnt = 0; busy_b_cnt = 0;
    run(3);
    chk("rst_tvalid_a", tvalid_a, 1'b0);
    chk("rst_tvalid_b", tvalid_b, 1'b0);
    chk("rst_gate_a", gate_a, '0);
    chk("rst_busy_a", busy_a, 1'b0);
    chk("rst_count_a", count_a, 16'h0);
    chk("tready_a", ready_a, 1'b1);
    rstn_a = 1'b1; rstn_b = 1'b1;
    tick();
    chk("tvalid_a_after_rst", tvalid_a, 1'b1);
    chk("tvalid_b_after_rst", tvalid_b, 1'b1);
    run(4);

    // Reset at OPEN count 3 aborts the window; capture held high through reset.
    pulse_a(t);
    push_a(t + 6, 3);
    run(8);
    cap_a = 1'b1;
    tick();
    rstn_a = 1'b0;
    tick();
    chk("abort_gate_zero", gate_a, '0);
    chk("abort_busy", busy_a, 1'b0);
    chk("abort_count", count_a, 16'h0);
    chk("abort_tvalid", tvalid_a, 1'b0);
    rstn_a = 1'b1;
    busy_a_cnt = 0;
    run(20);
    chk("held_high_no_window", 128'(busy_a_cnt), 128'(0));
    chk("abort_queue_drained", 128'(qa.size()), 128'(0));
    chk("abort_count_after", count_a, 16'h0);
    cap_a = 1'b0;
    run(6);

    // Basic window: busy at T+2, 8 beats starting T+7.
    beats_a = 0;
    pulse_a(t);
    chk("busy_at_T", busy_a, 1'b0);
    tick();
    chk("busy_at_T1", busy_a, 1'b0);
    tick();
    chk("busy_at_T2", busy_a, 1'b1);
    push_a(t + 6, 8);
    run(20);
    chk("basic_beats", 128'(beats_a), 128'(8));
    chk("basic_count", count_a, 16'd1);
    chk("basic_idle", busy_a, 1'b0);

    // Second edge during DELAY is ignored.
    beats_a = 0;
    pulse_a(t);
    push_a(t + 6, 8);
    run(2);
    pulse_a(t2);
    run(20);
    chk("delay_edge_beats", 128'(beats_a), 128'(8));
    chk("delay_edge_count", count_a, 16'd2);

    // Edge reaching the FSM at OPEN count 5.
    beats_a = 0;
    pulse_a(t);
`ifdef ADC_CAPTURE_GATE_RETRIGGER_EN
    exp_beats = 14;
`else
    exp_beats = 8;
`endif
    push_a(t + 6, exp_beats);
    run(9);
    pulse_a(t2);
    run(25);
    chk("retrig_beats", 128'(beats_a), 128'(exp_beats));
    chk("retrig_count", count_a, 16'd3);

    // Edge coincident with closure gives no back-to-back window.
    beats_a = 0;
    pulse_a(t);
    push_a(t + 6, 8);
    run(11);
    pulse_a(t2);
    run(20);
    chk("close_edge_beats", 128'(beats_a), 128'(8));
    chk("close_edge_count", count_a, 16'd4);
    chk("close_edge_idle", busy_a, 1'b0);

    // DELAY=0, LENGTH=1: one beat, busy for one cycle.
    beats_b = 0;
    busy_b_cnt = 0;
    pulse_b(t);
    chk("b_busy_T", busy_b, 1'b0);
    tick();
    chk("b_busy_T1", busy_b, 1'b0);
    tick();
    chk("b_busy_T2", busy_b, 1'b1);
    push_b(t + 2, 1);
    run(6);
    chk("b_beats", 128'(beats_b), 128'(1));
    chk("b_busy_cycles", 128'(busy_b_cnt), 128'(1));
    chk("b_count", count_b, 16'd1);

    // Window counter wrap from 0xFFFF.
    force u_b.window_count_o = 16'hFFFF;
    #1;
    release u_b.window_count_o;
    chk("b_preload", count_b, 16'hFFFF);
    beats_b = 0;
    pulse_b(t);
    push_b(t + 2, 1);
    run(6);
    chk("b_wrap_count", count_b, 16'h0000);
    chk("b_wrap_beats", 128'(beats_b), 128'(1));

    chk("a_queue_empty", 128'(qa.size()), 128'(0));
    chk("b_queue_empty", 128'(qb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
